// File: rtl/cond_issue_gate.sv
// cond_issue_gate: registered multi-lane ARM condition evaluator between
// decode and execute. Holds the architectural NZCV flags, counts in-flight
// flag setters, and either stalls or splits an issue group when a lane
// would read stale flags.
//
// Optional feature macro: COND_BYPASS_EN. When defined, a flag write
// retiring this cycle is forwarded into condition evaluation and the
// pending count, so a waiting lane issues in the same cycle as the write.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   in_valid/in_ready   input group handshake
//   in_inst             LANES x 32-bit instruction words (cond = [31:28])
//   in_lane_en          lanes carrying a real instruction
//   in_sets_flags       lanes that will later write NZCV
//   flag_wr/flag_nzcv   a flag setter retires with {N,Z,C,V}
//   out_valid/out_ready output piece handshake
//   out_lane_vld        lanes present in the output piece
//   out_inst            output instructions, absent lanes read zero
//   out_pass            resolved condition result per lane
//   cpsr_flags          architectural NZCV
//   pending             in-flight flag setter count
module cond_issue_gate #(
  parameter int unsigned LANES      = 2,
  parameter int unsigned PEND_DEPTH = 3,
  parameter int unsigned PW         = $clog2(PEND_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*LANES-1:0]   in_inst,
  input  logic [LANES-1:0]      in_lane_en,
  input  logic [LANES-1:0]      in_sets_flags,
  input  logic                  flag_wr,
  input  logic [3:0]            flag_nzcv,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES-1:0]      out_lane_vld,
  output logic [32*LANES-1:0]   out_inst,
  output logic [LANES-1:0]      out_pass,
  output logic [3:0]            cpsr_flags,
  output logic [PW-1:0]         pending
);

  typedef enum logic {RUN, SPLIT} state_t;

  state_t                state, state_n;
  logic [32*LANES-1:0]   res_inst, res_inst_n;
  logic [LANES-1:0]      res_en, res_en_n;
  logic [LANES-1:0]      res_sf, res_sf_n;
  logic                  out_valid_n;
  logic [LANES-1:0]      out_lane_vld_n;
  logic [32*LANES-1:0]   out_inst_n;
  logic [LANES-1:0]      out_pass_n;
  logic [3:0]            cpsr_flags_n;
  logic [PW-1:0]         pending_n;

  // Candidate group and per-lane decisions
  logic [32*LANES-1:0]   cand_inst;
  logic [LANES-1:0]      cand_en, cand_sf;
  logic [3:0]            eff_flags;
  logic [PW-1:0]         eff_pend, pend_dec;
  logic [LANES-1:0]      hz, emit, keep, pass_vec;
  logic                  lower_sf, hit, head_hz, fits, loadable, go, advance;
  logic [3:0]            lane_cond;
  int unsigned           set_cnt, pend_inc;

  // ARM condition table over {N,Z,C,V}
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cond)
      4'h0: cond_pass = z;
      4'h1: cond_pass = ~z;
      4'h2: cond_pass = c;
      4'h3: cond_pass = ~c;
      4'h4: cond_pass = n;
      4'h5: cond_pass = ~n;
      4'h6: cond_pass = v;
      4'h7: cond_pass = ~v;
      4'h8: cond_pass = c & ~z;
      4'h9: cond_pass = ~c | z;
      4'hA: cond_pass = (n == v);
      4'hB: cond_pass = (n != v);
      4'hC: cond_pass = ~z & (n == v);
      4'hD: cond_pass = z | (n != v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      res_inst     <= '0;
      res_en       <= '0;
      res_sf       <= '0;
      out_valid    <= 1'b0;
      out_lane_vld <= '0;
      out_inst     <= '0;
      out_pass     <= '0;
      cpsr_flags   <= 4'b0000;
      pending      <= '0;
    end else begin
      state        <= state_n;
      res_inst     <= res_inst_n;
      res_en       <= res_en_n;
      res_sf       <= res_sf_n;
      out_valid    <= out_valid_n;
      out_lane_vld <= out_lane_vld_n;
      out_inst     <= out_inst_n;
      out_pass     <= out_pass_n;
      cpsr_flags   <= cpsr_flags_n;
      pending      <= pending_n;
    end
  end

  // Next-state, piece formation and handshake
  always_comb begin
    state_n        = state;
    res_inst_n     = res_inst;
    res_en_n       = res_en;
    res_sf_n       = res_sf;
    out_valid_n    = out_valid;
    out_lane_vld_n = out_lane_vld;
    out_inst_n     = out_inst;
    out_pass_n     = out_pass;
    cpsr_flags_n   = cpsr_flags;
    hz             = '0;
    emit           = '0;
    keep           = '0;
    pass_vec       = '0;
    lower_sf       = 1'b0;
    hit            = 1'b0;
    set_cnt        = 0;
    lane_cond      = 4'h0;

    pend_dec = (flag_wr && (pending != '0)) ? pending - PW'(1) : pending;
`ifdef COND_BYPASS_EN
    eff_flags = flag_wr ? flag_nzcv : cpsr_flags;
    eff_pend  = pend_dec;
`else
    eff_flags = cpsr_flags;
    eff_pend  = pending;
`endif

    cand_inst = (state == SPLIT) ? res_inst : in_inst;
    cand_en   = (state == SPLIT) ? res_en   : in_lane_en;
    cand_sf   = (state == SPLIT) ? res_sf   : in_sets_flags;

    // Lanes before the first hazard are emitted; from it onward they are kept
    for (int i = 0; i < int'(LANES); i++) begin
      lane_cond   = cand_inst[32*i+28 +: 4];
      pass_vec[i] = cond_pass(lane_cond, eff_flags);
      hz[i]       = cand_en[i] && (lane_cond < 4'hE) && ((eff_pend != '0) || lower_sf);
      if (cand_en[i] && cand_sf[i]) lower_sf = 1'b1;
      if (hz[i]) hit = 1'b1;
      if (hit) keep[i] = cand_en[i];
      else     emit[i] = cand_en[i];
    end
    for (int i = 0; i < int'(LANES); i++) begin
      set_cnt = set_cnt + 32'(emit[i] & cand_sf[i]);
    end

    // A hazard with nothing emitted means the lowest enabled lane is stuck
    head_hz  = hit && (emit == '0);
    fits     = (32'(eff_pend) + set_cnt) <= PEND_DEPTH;
    loadable = !out_valid || out_ready;
    go       = loadable && !head_hz && fits;
    in_ready = (state == RUN) && go && !reset;
    advance  = (state == RUN) ? (in_valid && in_ready) : go;
    pend_inc = advance ? set_cnt : 0;

    case (state)
      RUN:     if (advance && hit) state_n = SPLIT;
      SPLIT:   if (advance && !hit) state_n = RUN;
      default: state_n = RUN;
    endcase

    if (advance) begin
      res_inst_n = hit ? cand_inst : '0;
      res_en_n   = keep;
      res_sf_n   = hit ? cand_sf : '0;
    end

    // Output register: load a non-empty piece, otherwise drain on consume
    if (advance && (emit != '0)) begin
      out_valid_n    = 1'b1;
      out_lane_vld_n = emit;
      out_pass_n     = emit & pass_vec;
      for (int i = 0; i < int'(LANES); i++) begin
        out_inst_n[32*i +: 32] = emit[i] ? cand_inst[32*i +: 32] : 32'h0;
      end
    end else if (out_ready) begin
      out_valid_n    = 1'b0;
      out_lane_vld_n = '0;
      out_inst_n     = '0;
      out_pass_n     = '0;
    end

    if (flag_wr) cpsr_flags_n = flag_nzcv;
    pending_n = PW'(32'(pend_dec) + pend_inc);
  end

endmodule

// File: tb/tb_cond_issue_gate.sv
// Scoreboard bench for cond_issue_gate with LANES=2, PEND_DEPTH=3.
module tb_cond_issue_gate;

`ifdef COND_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [63:0] in_inst;
  logic [1:0]  in_lane_en, in_sets_flags;
  logic        flag_wr;
  logic [3:0]  flag_nzcv;
  logic        out_valid, out_ready;
  logic [1:0]  out_lane_vld, out_pass;
  logic [63:0] out_inst;
  logic [3:0]  cpsr_flags;
  logic [1:0]  pending;

  cond_issue_gate #(.LANES(2), .PEND_DEPTH(3)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_lane_en(in_lane_en), .in_sets_flags(in_sets_flags),
    .flag_wr(flag_wr), .flag_nzcv(flag_nzcv),
    .out_valid(out_valid), .out_ready(out_ready), .out_lane_vld(out_lane_vld),
    .out_inst(out_inst), .out_pass(out_pass),
    .cpsr_flags(cpsr_flags), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  vld;
    logic [63:0] inst;
    logic [1:0]  pass;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mk(input logic [3:0] c, input logic [27:0] id);
    return {c, id};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic push(input logic [1:0] vld, input logic [63:0] inst, input logic [1:0] pass);
    exp_t x;
    x.vld  = vld;
    x.inst = inst;
    x.pass = pass;
    q.push_back(x);
  endtask

  // Monitor: compare each piece the consumer takes against the scoreboard
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_piece got vld %b inst %h expected none", out_lane_vld, out_inst);
      end else begin
        e = q.pop_front();
        chk("piece_vld", 64'(out_lane_vld), 64'(e.vld));
        chk("piece_inst", out_inst, e.inst);
        chk("piece_pass", 64'(out_pass), 64'(e.pass));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic clr_in();
    in_valid      = 1'b0;
    in_inst       = '0;
    in_lane_en    = '0;
    in_sets_flags = '0;
  endtask

  // Present a group and hold it until accepted, bounded
  task automatic issue(input logic [63:0] inst, input logic [1:0] en, input logic [1:0] sf);
    int n;
    n             = 0;
    in_inst       = inst;
    in_lane_en    = en;
    in_sets_flags = sf;
    in_valid      = 1'b1;
    #1;
    while (!in_ready && n < 20) begin
      cyc();
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got in_ready 0 expected 1");
    end else begin
      cyc();
    end
    clr_in();
  endtask

  task automatic flag_pulse(input logic [3:0] f, input int n);
    flag_wr   = 1'b1;
    flag_nzcv = f;
    idle(n);
    flag_wr   = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    clr_in();
    flag_wr   = 1'b0;
    flag_nzcv = 4'h0;
    out_ready = 1'b1;

    // Reset state, with a group presented
    in_valid   = 1'b1;
    in_lane_en = 2'b01;
    in_inst    = {32'h0, mk(4'hE, 28'h1)};
    idle(2);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_lane_vld", 64'(out_lane_vld), 0);
    chk("rst_inst", out_inst, 0);
    chk("rst_pass", 64'(out_pass), 0);
    chk("rst_flags", 64'(cpsr_flags), 0);
    chk("rst_pending", 64'(pending), 0);
    chk("rst_in_ready", 64'(in_ready), 0);
    clr_in();
    reset = 1'b0;
    idle(1);

    // Flag update: EQ fails on 0000, passes after Z is written
    push(2'b01, {32'h0, mk(4'h0, 28'h11)}, 2'b00);
    issue({32'h0, mk(4'h0, 28'h11)}, 2'b01, 2'b00);
    flag_pulse(4'b0100, 1);
    chk("flag_written", 64'(cpsr_flags), 64'h4);
    chk("pending_floor", 64'(pending), 0);
    push(2'b01, {32'h0, mk(4'h0, 28'h12)}, 2'b01);
    issue({32'h0, mk(4'h0, 28'h12)}, 2'b01, 2'b00);

    // Intra-group split: ADDS then EQ
    flag_pulse(4'b0000, 1);
    push(2'b01, {32'h0, mk(4'hE, 28'h21)}, 2'b01);
    issue({mk(4'h0, 28'h22), mk(4'hE, 28'h21)}, 2'b11, 2'b01);
    chk("split_lane_vld", 64'(out_lane_vld), 64'h1);
    chk("split_pending", 64'(pending), 1);
    chk("split_in_ready", 64'(in_ready), 0);
    idle(1);
    chk("split_stalled", 64'(out_valid), 0);
    push(2'b10, {mk(4'h0, 28'h22), 32'h0}, 2'b10);
    flag_pulse(4'b0100, 1);
    chk("residue_edge1", 64'(out_valid), 64'(BYP));
    idle(1);
    chk("residue_edge2", 64'(out_valid), 64'(!BYP));
    chk("split_done_pending", 64'(pending), 0);
    chk("split_done_ready", 64'(in_ready), 1);
    idle(2);

    // Backpressure: hold A for three cycles while B waits
    out_ready = 1'b0;
    issue({mk(4'hE, 28'h32), mk(4'hE, 28'h31)}, 2'b11, 2'b00);
    push(2'b11, {mk(4'hE, 28'h32), mk(4'hE, 28'h31)}, 2'b11);
    in_inst    = {mk(4'h0, 28'h42), mk(4'h4, 28'h41)};
    in_lane_en = 2'b11;
    in_valid   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 64'(in_ready), 0);
      chk("bp_inst", out_inst, {mk(4'hE, 28'h32), mk(4'hE, 28'h31)});
      chk("bp_pass", 64'(out_pass), 64'h3);
      cyc();
    end
    out_ready = 1'b1;
    push(2'b11, {mk(4'h0, 28'h42), mk(4'h4, 28'h41)}, 2'b10);
    #1;
    chk("bp_release_ready", 64'(in_ready), 1);
    cyc();
    clr_in();
    chk("bp_next_inst", out_inst, {mk(4'h0, 28'h42), mk(4'h4, 28'h41)});
    idle(1);

    // Pending saturation
    push(2'b11, {mk(4'hE, 28'h52), mk(4'hE, 28'h51)}, 2'b11);
    issue({mk(4'hE, 28'h52), mk(4'hE, 28'h51)}, 2'b11, 2'b11);
    chk("sat_pending2", 64'(pending), 2);
    in_inst       = {mk(4'hE, 28'h62), mk(4'hE, 28'h61)};
    in_lane_en    = 2'b11;
    in_sets_flags = 2'b11;
    in_valid      = 1'b1;
    #1;
    chk("sat_stall", 64'(in_ready), 0);
    cyc();
    chk("sat_stall2", 64'(in_ready), 0);
    push(2'b11, {mk(4'hE, 28'h62), mk(4'hE, 28'h61)}, 2'b11);
    flag_wr   = 1'b1;
    flag_nzcv = 4'b1001;
    #1;
    chk("sat_ready_on_wr", 64'(in_ready), 64'(BYP));
    cyc();
    flag_wr = 1'b0;
    if (!BYP) begin
      chk("sat_pending1", 64'(pending), 1);
      chk("sat_ready", 64'(in_ready), 1);
      cyc();
    end
    clr_in();
    chk("sat_pending3", 64'(pending), 3);
    flag_pulse(4'b1001, 3);
    chk("drain_pending", 64'(pending), 0);
    chk("drain_flags", 64'(cpsr_flags), 64'h9);

    // Condition table with N=1 Z=0 C=0 V=1
    push(2'b11, {mk(4'hB, 28'h72), mk(4'hA, 28'h71)}, 2'b01);
    issue({mk(4'hB, 28'h72), mk(4'hA, 28'h71)}, 2'b11, 2'b00);
    push(2'b11, {mk(4'hF, 28'h74), mk(4'hC, 28'h73)}, 2'b01);
    issue({mk(4'hF, 28'h74), mk(4'hC, 28'h73)}, 2'b11, 2'b00);
    push(2'b11, {mk(4'h9, 28'h76), mk(4'h8, 28'h75)}, 2'b10);
    issue({mk(4'h9, 28'h76), mk(4'h8, 28'h75)}, 2'b11, 2'b00);
    push(2'b11, {mk(4'h6, 28'h78), mk(4'h4, 28'h77)}, 2'b11);
    issue({mk(4'h6, 28'h78), mk(4'h4, 28'h77)}, 2'b11, 2'b00);
    push(2'b11, {mk(4'h1, 28'h7A), mk(4'h2, 28'h79)}, 2'b10);
    issue({mk(4'h1, 28'h7A), mk(4'h2, 28'h79)}, 2'b11, 2'b00);
    push(2'b11, {mk(4'h5, 28'h7C), mk(4'hD, 28'h7B)}, 2'b00);
    issue({mk(4'h5, 28'h7C), mk(4'hD, 28'h7B)}, 2'b11, 2'b00);
    push(2'b11, {mk(4'h3, 28'h7E), mk(4'h7, 28'h7D)}, 2'b10);
    issue({mk(4'h3, 28'h7E), mk(4'h7, 28'h7D)}, 2'b11, 2'b00);

    // AL never stalls on pending; a conditional head lane does
    push(2'b01, {32'h0, mk(4'hE, 28'h81)}, 2'b01);
    issue({32'h0, mk(4'hE, 28'h81)}, 2'b01, 2'b01);
    push(2'b11, {mk(4'hE, 28'h83), mk(4'hE, 28'h82)}, 2'b11);
    issue({mk(4'hE, 28'h83), mk(4'hE, 28'h82)}, 2'b11, 2'b00);
    chk("al_pending", 64'(pending), 1);
    in_inst    = {32'h0, mk(4'h0, 28'h84)};
    in_lane_en = 2'b01;
    in_valid   = 1'b1;
    #1;
    chk("head_hazard_stall", 64'(in_ready), 0);
    clr_in();
    flag_pulse(4'b1001, 1);
    chk("al_drain", 64'(pending), 0);

    // Empty group is accepted and produces nothing
    issue(64'h0, 2'b00, 2'b00);
    chk("empty_no_out", 64'(out_valid), 0);

    // Reset while residue is held
    push(2'b01, {32'h0, mk(4'hE, 28'h91)}, 2'b01);
    issue({mk(4'h0, 28'h92), mk(4'hE, 28'h91)}, 2'b11, 2'b01);
    chk("pre_rst_split", 64'(in_ready), 0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 0);
    chk("mid_rst_lane_vld", 64'(out_lane_vld), 0);
    chk("mid_rst_inst", out_inst, 0);
    chk("mid_rst_pass", 64'(out_pass), 0);
    chk("mid_rst_pending", 64'(pending), 0);
    chk("mid_rst_flags", 64'(cpsr_flags), 0);
    chk("mid_rst_ready", 64'(in_ready), 0);
    cyc();
    reset = 1'b0;
    push(2'b11, {mk(4'h3, 28'hA2), mk(4'h1, 28'hA1)}, 2'b11);
    issue({mk(4'h3, 28'hA2), mk(4'h1, 28'hA1)}, 2'b11, 2'b00);
    chk("post_rst_pending", 64'(pending), 0);

    idle(3);
    chk("scoreboard_empty", 64'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
